aes_key_schedule: RTL and testbench

Iterative AES-128 key expansion engine for the core datapath. It sits directly upstream of `add_round_key` and supplies its `round_key` operand. Given a 128-bit cipher key, it produces the 11 round keys (round 0 to 10) in order, one per accepted handshake. Output flows through a valid/ready interface so the round datapath can stall it.

---
 rtl/aes_key_schedule.sv | 146 ++++++++++++++
 tb/tb_aes_key_schedule.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule
// Description : Iterative AES-128 key expansion. Emits round keys 0..10 one per
//               valid/ready handshake, with no bubble between rounds.
//               Optional feature macro AES_KEY_STORE_EN adds an 11-entry round
//               key store with a combinational read port (rd_idx/rd_key).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
`ifdef AES_KEY_STORE_EN
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
`endif
    output logic         rk_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    // AES S-box, byte 0x00 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] top;
        top  = ~{x, 3'b000};   // 2047 - 8*x: MSB of entry x
        sbox = c_SBOX[top -: 8];
    endfunction

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [127:0] r_key;
    logic [3:0]   r_idx;
    logic [7:0]   r_rcon;
    logic         r_done;

    logic         w_accept;
    logic         w_hs;
    logic         w_last;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot, w_t;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [127:0] w_next_key;
    logic [7:0]   w_rcon_nxt;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_hs     = (r_state == ST_EMIT) && rk_ready;
    assign w_last   = (r_idx == 4'd10);

    assign w_w0 = r_key[127:96];
    assign w_w1 = r_key[95:64];
    assign w_w2 = r_key[63:32];
    assign w_w3 = r_key[31:0];

    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_t   = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                    sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {r_rcon, 24'h0};
    assign w_n0  = w_w0 ^ w_t;
    assign w_n1  = w_w1 ^ w_n0;
    assign w_n2  = w_w2 ^ w_n1;
    assign w_n3  = w_w3 ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: leave IDLE on start, return after the round-10 handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)           w_state_nxt = ST_EMIT;
            ST_EMIT: if (rk_ready && w_last) w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // Key/round/rcon datapath and the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key  <= '0;
            r_idx  <= '0;
            r_rcon <= 8'h01;
            r_done <= 1'b0;
        end else begin
            r_done <= w_hs && w_last;
            if (w_accept) begin
                r_key  <= key_in;
                r_idx  <= '0;
                r_rcon <= 8'h01;
            end else if (w_hs && !w_last) begin
                r_key  <= w_next_key;
                r_idx  <= r_idx + 4'd1;
                r_rcon <= w_rcon_nxt;
            end
        end
    end

    assign rk_valid  = (r_state == ST_EMIT);
    assign busy      = (r_state == ST_EMIT);
    assign done      = r_done;
    assign round_key = r_key;
    assign round_idx = r_idx;

`ifdef AES_KEY_STORE_EN
    logic [127:0] r_store [0:10];

    // Capture each round key as it is presented; a new start wipes old keys.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) r_store[i] <= '0;
        end else if (w_accept) begin
            for (int i = 1; i < 11; i++) r_store[i] <= '0;
            r_store[0] <= key_in;
        end else if (w_hs && !w_last) begin
            r_store[r_idx + 4'd1] <= w_next_key;
        end
    end

    assign rd_key = (rd_idx <= 4'd10) ? r_store[rd_idx] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_schedule
// Description : Table-driven, scoreboard-checked bench for aes_key_schedule.
//               Exercises AES_KEY_STORE_EN read-back when that macro is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule;

    localparam logic [127:0] c_KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_B_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
`endif

    aes_key_schedule dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
`ifdef AES_KEY_STORE_EN
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
`endif
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           set;
        logic [3:0]   idx;
        logic [127:0] rk;
        bit           chk;
    } vec_t;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
        bit           chk;
    } exp_t;

    vec_t tbl [22];
    exp_t sbq [$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input int s, input int idx, input logic [127:0] rk, input bit chk);
        tbl[i].set = s;
        tbl[i].idx = idx[3:0];
        tbl[i].rk  = rk;
        tbl[i].chk = chk;
    endtask

    task automatic push_set(input int s);
        exp_t e;
        for (int i = 0; i < 22; i++) begin
            if (tbl[i].set == s) begin
                e.idx = tbl[i].idx;
                e.rk  = tbl[i].rk;
                e.chk = tbl[i].chk;
                sbq.push_back(e);
            end
        end
    endtask

    // One clock: score a handshake if one happens at this edge, then step.
    task automatic tick();
        exp_t e;
        if (rk_valid === 1'b1 && rk_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_key", {124'h0, round_idx}, 128'hffff);
            end else begin
                e = sbq.pop_front();
                check("sb_round_idx", {124'h0, round_idx}, {124'h0, e.idx});
                if (e.chk) check("sb_round_key", round_key, e.rk);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int s, input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        push_set(s);
        tick();
        start = 1'b0;
        check("start_valid", {127'h0, rk_valid}, 128'h1);
        check("start_busy", {127'h0, busy}, 128'h1);
        check("start_idx", {124'h0, round_idx}, 128'h0);
        check("start_round0", round_key, k);
    endtask

    task automatic run_to_done(input int stall_round, input int stall_len, input int poke_round,
                               input int exp_valid, input logic [127:0] r10);
        int stalls = 0;
        int nval   = 0;
        bit poked  = 0;
        logic [127:0] held;
        held = '0;
        for (int cyc = 0; cyc < 60 && done !== 1'b1; cyc++) begin
            start    = 1'b0;
            rk_ready = 1'b1;
            if (rk_valid === 1'b1) nval++;
            if (rk_valid === 1'b1 && int'(round_idx) == stall_round && stalls < stall_len) begin
                if (stalls == 0) begin
                    held = round_key;
                end else begin
                    check("stall_idx", {124'h0, round_idx}, stall_round);
                    check("stall_key", round_key, held);
                    check("stall_valid", {127'h0, rk_valid}, 128'h1);
                end
                rk_ready = 1'b0;
                stalls++;
            end
            if (rk_valid === 1'b1 && int'(round_idx) == poke_round && !poked) begin
                start  = 1'b1;
                key_in = ~c_KEY_B;
                poked  = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        check("done_pulse", {127'h0, done}, 128'h1);
        check("done_busy", {127'h0, busy}, 128'h0);
        check("done_valid", {127'h0, rk_valid}, 128'h0);
        check("done_round_key", round_key, r10);
        check("valid_cycles", nval, exp_valid);
        check("sb_drained", sbq.size(), 0);
    endtask

    initial begin
        // Set 0: FIPS-197 A.1 key, all rounds known.
        setv(0,  0, 0,  c_KEY_A1, 1);
        setv(1,  0, 1,  128'ha0fafe1788542cb123a339392a6c7605, 1);
        setv(2,  0, 2,  128'hf2c295f27a96b9435935807a7359f67f, 1);
        setv(3,  0, 3,  128'h3d80477d4716fe3e1e237e446d7a883b, 1);
        setv(4,  0, 4,  128'hef44a541a8525b7fb671253bdb0bad00, 1);
        setv(5,  0, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1);
        setv(6,  0, 6,  128'h6d88a37a110b3efddbf98641ca0093fd, 1);
        setv(7,  0, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1);
        setv(8,  0, 8,  128'head27321b58dbad2312bf5607f8d292f, 1);
        setv(9,  0, 9,  128'hac7766f319fadc2128d12941575c006e, 1);
        setv(10, 0, 10, c_A1_R10, 1);
        // Set 1: sequential-byte key; round index checked for every round.
        setv(11, 1, 0,  c_KEY_B, 1);
        setv(12, 1, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, 1);
        for (int r = 2; r < 10; r++) setv(11 + r, 1, r, '0, 0);
        setv(21, 1, 10, c_B_R10, 1);

        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
`ifdef AES_KEY_STORE_EN
        rd_idx   = '0;
`endif
        tick();
        tick();
        check("reset_valid", {127'h0, rk_valid}, 128'h0);
        check("reset_busy", {127'h0, busy}, 128'h0);
        check("reset_done", {127'h0, done}, 128'h0);
        check("reset_key", round_key, 128'h0);
        check("reset_idx", {124'h0, round_idx}, 128'h0);
        rst = 1'b0;
        tick();

        // A.1 streaming with ready held high.
        do_start(0, c_KEY_A1);
        run_to_done(-1, 0, -1, 11, c_A1_R10);
        tick();
        check("done_single_cycle", {127'h0, done}, 128'h0);
        check("idle_key_held", round_key, c_A1_R10);
`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd1;  #1; check("store_rd1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_idx = 4'd10; #1; check("store_rd10", rd_key, c_A1_R10);
        rd_idx = 4'd15; #1; check("store_rd15", rd_key, 128'h0);
        rd_idx = 4'd0;  #1; check("store_rd0", rd_key, c_KEY_A1);
`endif

        // Second key, contiguous round indices.
        do_start(1, c_KEY_B);
        run_to_done(-1, 0, -1, 11, c_B_R10);

        // Backpressure at round 4, ignored start at round 3, start in done cycle.
        do_start(0, c_KEY_A1);
        run_to_done(4, 5, 3, 16, c_A1_R10);
        do_start(1, c_KEY_B);
        run_to_done(-1, 0, -1, 11, c_B_R10);

        // Reset in the middle of an expansion.
        do_start(0, c_KEY_A1);
        rk_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && round_idx !== 4'd6; cyc++) tick();
        check("reached_round6", {124'h0, round_idx}, 128'h6);
        rk_ready = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        sbq.delete();
        check("midrst_valid", {127'h0, rk_valid}, 128'h0);
        check("midrst_busy", {127'h0, busy}, 128'h0);
        check("midrst_key", round_key, 128'h0);
        check("midrst_idx", {124'h0, round_idx}, 128'h0);
`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd1; #1; check("midrst_store", rd_key, 128'h0);
`endif
        for (int k = 0; k < 3; k++) begin
            check("midrst_no_done", {127'h0, done}, 128'h0);
            tick();
        end
        do_start(0, c_KEY_A1);
        run_to_done(-1, 0, -1, 11, c_A1_R10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
